// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
package mod_exp_pkg;

   localparam int DATA_W      = 32;
   localparam int PROD_KEEP_W = 40;
   localparam logic [DATA_W-1:0] N_MAX = 32'h000F_FFFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      REDUCE = 3'd2,
      SQR    = 3'd3,
      MUL    = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mod_exp_ctrl_msb_find.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
module msb_find
   import mod_exp_pkg::*;
#(
   parameter int W     = 32,
   parameter int IDX_W = idx_width(W)
) (
   input  logic [W-1:0]     value,
   output logic [IDX_W-1:0] msb,
   output logic             zero
);

   always_comb begin
      msb  = '0;
      zero = (value == '0);
      for (int i = 0; i < W; i++) begin
         if (value[i]) msb = IDX_W'(i);
      end
   end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared external multi_mod.
// Optional build macro MODEXP_LZ_SKIP_EN: start at the exponent's highest set bit.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on the accepting edge
// LOAD   | init acc and bit index; n==0 short-circuits to DONE with err
// REDUCE | base_r = base mod n via base*1
// SQR    | acc = acc*acc mod n for the current exponent bit
// MUL    | acc = acc*base_r mod n when the current bit is 1
// DONE   | one-cycle done pulse, result valid
module mod_exp_ctrl
   import mod_exp_pkg::*;
#(
   parameter int EXP_W  = 32,
   parameter int MM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] base,
   input  logic [EXP_W-1:0]  exp,
   input  logic [DATA_W-1:0] n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] mm_a,
   output logic [DATA_W-1:0] mm_b,
   output logic [DATA_W-1:0] mm_n,
   input  logic [DATA_W-1:0] mm_out
);

   localparam int IDX_W = idx_width(EXP_W);
   localparam int CNT_W = (MM_LAT > 0) ? $clog2(MM_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_LAT);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_W - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] base_r, acc, n_r, result_r;
   logic [DATA_W-1:0] mm_a_q, mm_b_q;
   logic [EXP_W-1:0]  exp_r;
   logic [IDX_W-1:0]  bit_idx, load_idx;
   logic [CNT_W-1:0]  cnt;
   logic              err_r;
   logic              op_last, bit_set, last_bit, exp_zero;

`ifdef MODEXP_LZ_SKIP_EN
   logic [IDX_W-1:0] msb_idx;
   logic             msb_zero;

   msb_find #(.W(EXP_W), .IDX_W(IDX_W)) u_msb_find (
      .value (exp_r),
      .msb   (msb_idx),
      .zero  (msb_zero)
   );

   assign load_idx = msb_idx;
   assign exp_zero = msb_zero;
`else
   assign load_idx = IDX_TOP;
   assign exp_zero = 1'b0;
`endif

   assign op_last  = (cnt == CNT_LAST);
   assign bit_set  = exp_r[bit_idx];
   assign last_bit = (bit_idx == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mm_a      = mm_a_q;
      mm_b      = mm_b_q;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            busy      = 1'b1;
            state_nxt = (n_r == '0) ? DONE : REDUCE;
         end
         REDUCE: begin
            busy = 1'b1;
            mm_a = base_r;
            mm_b = DATA_W'(1);
            if (op_last) state_nxt = exp_zero ? DONE : SQR;
         end
         SQR: begin
            busy = 1'b1;
            mm_a = acc;
            mm_b = acc;
            if (op_last) begin
               if (bit_set)       state_nxt = MUL;
               else if (last_bit) state_nxt = DONE;
               else               state_nxt = SQR;
            end
         end
         MUL: begin
            busy = 1'b1;
            mm_a = acc;
            mm_b = base_r;
            if (op_last) state_nxt = last_bit ? DONE : SQR;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_r   <= '0;
         exp_r    <= '0;
         n_r      <= '0;
         acc      <= '0;
         result_r <= '0;
         err_r    <= 1'b0;
         bit_idx  <= '0;
         cnt      <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
      end else begin
         mm_a_q <= mm_a;
         mm_b_q <= mm_b;
         case (state)
            IDLE: begin
               if (start) begin
                  base_r <= base;
                  exp_r  <= exp;
                  n_r    <= n;
                  err_r  <= 1'b0;
               end
            end
            LOAD: begin
               acc     <= (n_r == DATA_W'(1)) ? '0 : DATA_W'(1);
               bit_idx <= load_idx;
               cnt     <= '0;
               if (n_r == '0) begin
                  err_r    <= 1'b1;
                  result_r <= '0;
               end
            end
            REDUCE: begin
               if (op_last) begin
                  base_r <= mm_out;
                  cnt    <= '0;
                  // Zero exponent with leading-zero skip: acc already holds 1 mod n
                  if (exp_zero) result_r <= acc;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SQR, MUL: begin
               if (op_last) begin
                  acc <= mm_out;
                  cnt <= '0;
                  if (state_nxt == DONE)     result_r <= mm_out;
                  else if (state_nxt == SQR) bit_idx  <= bit_idx - IDX_W'(1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign err    = err_r;
   assign result = result_r;
   assign mm_n   = n_r;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural multi_mod model alongside.
module tb_mod_exp_ctrl;
   import mod_exp_pkg::*;

   localparam int EXP_W  = 16;
   localparam int MM_LAT = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [31:0]       base = '0;
   logic [EXP_W-1:0]  exp = '0;
   logic [31:0]       n = '0;
   logic              busy, done, err;
   logic [31:0]       result, mm_a, mm_b, mm_n, mm_out;

   always #5 clk = ~clk;

   mod_exp_ctrl #(.EXP_W(EXP_W), .MM_LAT(MM_LAT)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .base   (base),
      .exp    (exp),
      .n      (n),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result),
      .mm_a   (mm_a),
      .mm_b   (mm_b),
      .mm_n   (mm_n),
      .mm_out (mm_out)
   );

   // multi_mod: MM_LAT register stages on the product, keep 40 bits, combinational mod n
   logic [63:0] prod;
   logic [39:0] pipe [MM_LAT];
   assign prod = 64'(mm_a) * 64'(mm_b);
   always @(posedge clk) begin
      pipe[0] <= prod[39:0];
      for (int i = 1; i < MM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mm_out = (mm_n == 0) ? 32'd0 : 32'(pipe[MM_LAT-1] % {8'd0, mm_n});

   typedef struct {
      logic [31:0] res;
      logic        err;
      longint      done_cyc;
   } exp_t;

   exp_t   sb[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [EXP_W-1:0] e,
                                           input logic [31:0] nn);
      longint unsigned r, x, m;
      if (nn == 0) return 32'd0;
      m = longint'(nn);
      r = 1 % m;
      x = longint'(b) % m;
      for (int i = 0; i < EXP_W; i++) begin
         if (e[i]) r = (r * x) % m;
         x = (x * x) % m;
      end
      return 32'(r);
   endfunction

   function automatic longint ref_lat(input logic [EXP_W-1:0] e, input logic [31:0] nn);
      int ops;
      int pc;
      pc = $countones(e);
      if (nn == 0) return 1;
`ifdef MODEXP_LZ_SKIP_EN
      if (e == 0) ops = 1;
      else begin
         int top;
         top = 0;
         for (int i = 0; i < EXP_W; i++) if (e[i]) top = i;
         ops = 1 + (top + 1) + pc;
      end
`else
      ops = 1 + EXP_W + pc;
`endif
      return longint'(1 + ops * (MM_LAT + 1));
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", longint'(result), longint'(e.res));
            check("err", longint'(err), longint'(e.err));
            check("done_cycle", cyc, e.done_cyc);
         end
      end
   end

   task automatic issue(input logic [31:0] b, input logic [EXP_W-1:0] e, input logic [31:0] nn);
      exp_t x;
      @(negedge clk);
      start = 1'b1;
      base  = b;
      exp   = e;
      n     = nn;
      x.res      = ref_pow(b, e, nn);
      x.err      = (nn == 0);
      x.done_cyc = cyc + 1 + ref_lat(e, nn);
      sb.push_back(x);
      @(negedge clk);
      start = 1'b0;
      base  = $urandom;
      exp   = EXP_W'($urandom);
      n     = $urandom;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},   longint'(busy),   0);
      check({tag, "_done"},   longint'(done),   0);
      check({tag, "_err"},    longint'(err),    0);
      check({tag, "_result"}, longint'(result), 0);
      check({tag, "_mm_a"},   longint'(mm_a),   0);
      check({tag, "_mm_b"},   longint'(mm_b),   0);
      check({tag, "_mm_n"},   longint'(mm_n),   0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      issue(32'd5, 16'd3, 32'd13);        wait_idle();
      issue(32'd65, 16'd17, 32'd3233);    wait_idle();
      issue(32'd2790, 16'd2753, 32'd3233); wait_idle();
      issue(32'd7, 16'd0, 32'd10);        wait_idle();
      issue(32'd7, 16'd0, 32'd1);         wait_idle();
      issue(32'd100, 16'd5, 32'd0);       wait_idle();
      issue(32'd20, 16'd2, 32'd13);       wait_idle();

      // start while busy must be ignored
      issue(32'd65, 16'd17, 32'd3233);
      repeat (8) @(negedge clk);
      start = 1'b1; base = 32'd3; exp = 16'd5; n = 32'd7;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_ignored_start", longint'(busy), 1);
      wait_idle();

      // start in the DONE cycle must be ignored
      issue(32'd5, 16'd3, 32'd13);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_seen", longint'(done), 1);
      start = 1'b1; base = 32'd9; exp = 16'd9; n = 32'd11;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done_start", longint'(busy), 0);
      repeat (120) @(negedge clk);
      wait_idle();

      // reset in the middle of SQR
      issue(32'd12345, 16'hFFFF, 32'd999983);
      repeat (8) @(negedge clk);
      check("busy_before_reset", longint'(busy), 1);
      reset = 1'b0;
      #1;
      check_zero_outputs("midreset");
      sb.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (120) @(negedge clk);
      issue(32'd5, 16'd3, 32'd13);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         logic [31:0] nn;
         logic [EXP_W-1:0] ee;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      nn = 32'd0;
         else if (sel == 1) nn = 32'd1;
         else if (sel < 5)  nn = $urandom_range(2, 50);
         else               nn = $urandom_range(2, 32'(N_MAX));
         if ($urandom_range(0, 3) == 0) ee = EXP_W'($urandom_range(0, 3));
         else                           ee = EXP_W'($urandom);
         issue($urandom, ee, nn);
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequencer computing result = base^exp mod n by left-to-right square-and-multiply.
- Time-multiplexes one external multi_mod (registered multiplier followed by combinational 40-bit reduction) through an operand/result port pair.
- Sits between the RSA top-level key/message registers and the shared multi_mod instance.
- Serves both encryption (e) and decryption (d).

Parameters:
- EXP_W, 32: exponent width in bits, range 1..32.
- MM_LAT, 2: clock cycles from mm_a/mm_b valid to mm_out valid; must match the Gowin_MULT configuration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request pulse; sampled only in IDLE.
- base  in  32  message or ciphertext; sampled with start.
- exp  in  EXP_W  exponent; sampled with start.
- n  in  32  modulus; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  n==0 on the accepted request; valid with done, held until the next start.
- result  out  32  final value; held from done until the next accepted start.
- mm_a  out  32  multi_mod operand a.
- mm_b  out  32  multi_mod operand b.
- mm_n  out  32  multi_mod modulus.
- mm_out  in  32  multi_mod remainder.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, err, result, mm_a, mm_b, mm_n all 0; internal registers cleared.
- Reset asserted mid-operation aborts immediately with no done pulse. After release, the block idles until a new start.
- States:
  - IDLE -> LOAD on start.
  - LOAD -> REDUCE; the same transition goes LOAD -> DONE with err=1, result=0 if n==0.
  - REDUCE -> SQR.
  - SQR -> MUL if current exponent bit is 1. SQR -> SQR on the next lower bit if current bit is 0 and bits remain. SQR -> DONE if current bit is 0 and it is the last bit.
  - MUL -> SQR on the next lower bit if bits remain, else MUL -> DONE.
  - DONE -> IDLE.
- LOAD (1 cycle):
  - Latch base, exp, n; mm_n=n for the entire operation.
  - acc = (n==1) ? 0 : 1.
  - bit index = EXP_W-1.
- Op timing:
  - Each op state (REDUCE/SQR/MUL) drives mm_a/mm_b stable for exactly MM_LAT+1 cycles; an internal counter runs 0..MM_LAT.
  - mm_out is captured on the counter==MM_LAT cycle, then the state transitions.
- Op operands:
  - REDUCE: mm_a=base_r, mm_b=1; captures base_r = base mod n.
  - SQR: mm_a=mm_b=acc; captures acc.
  - MUL: mm_a=acc, mm_b=base_r; captures acc.
- exp==0: REDUCE plus EXP_W squarings of acc; result = 1 mod n.
- Op count without skip: 1 + EXP_W + popcount(exp). Latency from the start-sampling edge: 1 + ops*(MM_LAT+1) cycles to DONE.
- DONE (1 cycle): done=1, busy=0, result=acc.
- busy=1 in LOAD, REDUCE, SQR and MUL only.
- start outside IDLE is ignored, including in the DONE cycle. Nothing is queued.
- Width rule: multi_mod keeps only product bits [39:0]. Results are correct only for n < 2^20. Larger n gives unspecified results; no detection is done.
- mm_a/mm_b retain their last values in IDLE/DONE.

Optional Feature:
- Macro: MODEXP_LZ_SKIP_EN.
- Defined: in LOAD, bit index = position of the highest set bit of exp. Bits above it get no SQR/MUL. exp==0 goes REDUCE -> DONE with result = 1 mod n.
  - Op count = 1 + (msb+1) + popcount(exp).
  - Result is identical to the non-skip build.
- Undefined: all EXP_W bits are processed; latency depends only on popcount.

Decomposition:
- Package mod_exp_pkg:
  - State encoding IDLE/LOAD/REDUCE/SQR/MUL/DONE.
  - Width constant DATA_W=32.
  - Constant PROD_KEEP_W=40; modulus bound N_MAX = 2^20-1.
- One sub-module: msb_find, a combinational priority encoder returning the highest set bit index of exp plus a zero flag. Instantiated only under MODEXP_LZ_SKIP_EN.
- The multi_mod instance stays outside, in the RSA top.

Test Plan:
- EXP_W=8, MM_LAT=2, base=5, exp=3, n=13 -> result=8, err=0.
  - No skip: done exactly 34 cycles after the start edge.
  - With skip: 5 ops, done after 16 cycles.
- EXP_W=16, base=65, exp=17, n=3233 -> result=2790. Then base=2790, exp=2753, n=3233 -> result=65.
- base=7, exp=0, n=10 -> result=1. Same request with n=1 -> result=0.
- base=100, exp=5, n=0 -> done 2 cycles after start, err=1, result=0, no multi_mod ops.
- base=20, exp=2, n=13 (base >= n) -> REDUCE yields 7, result=10.
- Protocol cases:
  - start pulsed while busy -> ignored.
  - reset pulled low mid-SQR -> all outputs 0 immediately, no done pulse.
  - A new start after reset release computes correctly.
